avmm_mem_responder: RTL
=======================

# avmm_mem_responder

Avalon-MM slave that answers the 512-bit DRAM-side master ports of the MSPE wrapper (the DRAM→FIFO reader and FIFO→DRAM writer) from an on-chip word memory. Accepts single and burst reads/writes with waitrequest backpressure, queues read commands and returns data with a fixed pipelined latency. Used as the far end of those master ports in system simulation and in on-chip loopback builds.

## Interface
- MEM_DEPTH, 10, log2 of memory words (512-bit each)
- READ_LATENCY, 2, cycles from memory access to s_readdatavalid; legal 1..8
- CMDQ_DEPTH, 4, read-command queue entries; power of 2, ≥2
- BASE_ADDR, 64'h0, byte address mapped to word 0

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- s_waitrequest  out  1  stall current command
- s_readdata  out  512  read beat
- s_readdatavalid  out  1  read beat valid
- s_burstcount  in  3  beats per command
- s_writedata  in  512  write beat
- s_address  in  64  byte address (bits [5:0] ignored)
- s_write  in  1  write request
- s_read  in  1  read request
- s_byteenable  in  64  per-byte write enable
- rd_cmd_count  out  32  accepted read commands
- wr_beat_count  out  32  accepted write beats
- err_flags  out  2  sticky: [0] address out of range, [1] read+write asserted together

## Operation
- Word index = (s_address − BASE_ADDR) >> 6, truncated to MEM_DEPTH bits (wraps); if (s_address − BASE_ADDR) ≥ 64·2^MEM_DEPTH or s_address < BASE_ADDR, set err_flags[0], access still performed at wrapped index.
- Burstcount 0 treated as 1; 1..7 honoured. Burst index increments by 1 per beat, wrapping at 2^MEM_DEPTH.
- Write FSM: WR_IDLE, WR_BURST. In WR_IDLE, accepted write (s_write & !s_waitrequest) stores beat at index, captures index+1 and remaining = burstcount−1; goes WR_BURST if remaining>0. In WR_BURST each accepted beat writes next index, s_address/s_burstcount ignored; returns to WR_IDLE after last beat.
- Byte lane k written only when s_byteenable[k]=1.
- Read: accepted s_read pushes {index, count} into command queue. Read engine pops head, issues one memory read per cycle for count beats, then pops next with no bubble.
- Read data passes a READ_LATENCY-stage valid/data pipeline; s_readdatavalid never backpressured.
- Ordering: writes stall (waitrequest=1) while queue non-empty or engine/pipeline busy; reads stall while in WR_BURST. Hence no read/write hazard.
- s_waitrequest = 1 when: in reset; s_read & s_write both high (also sets err_flags[1]); s_read & (queue full | WR_BURST); s_write & read activity pending; else 0.
- Counters wrap at 2^32; increment on acceptance (rd_cmd_count per command, wr_beat_count per beat).

## Timing
- Reset (reset=0): s_waitrequest=1, s_readdatavalid=0, s_readdata=0, counters=0, err_flags=0, queue empty, FSM WR_IDLE, pipeline cleared. Memory contents not reset.
- Reset assertion mid-burst discards queued reads and in-flight beats; no readdatavalid after reset release until a new command.
- s_waitrequest combinational from inputs and state; deasserts first cycle after reset release.
- Read accepted cycle T with idle engine: first s_readdatavalid at T+1+READ_LATENCY; beats on consecutive cycles.
- Back-to-back read commands: continuous valid stream, no idle cycle between bursts.
- Write is committed in the acceptance cycle; a read accepted the next cycle returns the new data.
- Queue full and pop in same cycle: new read still stalled that cycle (full evaluated before pop).

## Configuration
- WAITREQ_INJECT_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11, reset seed 16'hACE1) advances every cycle; when LFSR[0]=1, s_waitrequest forced 1 that cycle in addition to structural causes. Data and ordering unaffected.
- Not defined: s_waitrequest from structural conditions only; LFSR absent.

## Test plan
- Single write 0x40 data A, byteenable all-ones, then read 0x40 burst 1 → readdatavalid at accept+1+READ_LATENCY with data A; wr_beat_count=1, rd_cmd_count=1.
- Burst write 4 beats from 0x0 (D0..D3), burst read 4 from 0x0 → 4 consecutive valid beats D0..D3.
- Byteenable 64'h0000_0000_0000_00FF over prior all-FF word with zeros → readback low 8 bytes 0, rest FF.
- Issue 5 single reads back-to-back with CMDQ_DEPTH=4, engine busy → waitrequest high on 5th until a pop; all 5 return in order.
- Write to address 64·2^MEM_DEPTH → err_flags[0]=1, data lands at word 0; read+write same cycle → waitrequest=1, err_flags[1]=1.
- Assert reset during 4-beat read after 2 beats returned → remaining beats never appear, outputs at reset values.

Source files
------------

// File: rtl/avmm_mem_responder.sv
// Avalon-MM 512-bit memory responder: burst writes, queued pipelined burst reads.
// Optional build macro WAITREQ_INJECT_EN adds LFSR-driven random waitrequest stalls.
module avmm_mem_responder #(
    parameter int          MEM_DEPTH    = 10,
    parameter int          READ_LATENCY = 2,
    parameter int          CMDQ_DEPTH   = 4,
    parameter logic [63:0] BASE_ADDR    = 64'h0
) (
    input  logic         clk,
    input  logic         reset,
    output logic         s_waitrequest,
    output logic [511:0] s_readdata,
    output logic         s_readdatavalid,
    input  logic [2:0]   s_burstcount,
    input  logic [511:0] s_writedata,
    input  logic [63:0]  s_address,
    input  logic         s_write,
    input  logic         s_read,
    input  logic [63:0]  s_byteenable,
    output logic [31:0]  rd_cmd_count,
    output logic [31:0]  wr_beat_count,
    output logic [1:0]   err_flags
);

    localparam int QA_W = $clog2(CMDQ_DEPTH);

    typedef enum logic [0:0] {
        WR_IDLE  = 1'b0,
        WR_BURST = 1'b1
    } wr_state_t;

    function automatic logic [2:0] eff_burst(input logic [2:0] bc);
        return (bc == 3'd0) ? 3'd1 : bc;
    endfunction

    logic [511:0]         mem_r [2**MEM_DEPTH];

    wr_state_t            wr_state_r;
    logic [MEM_DEPTH-1:0] wr_idx_r;
    logic [2:0]           wr_left_r;

    logic [MEM_DEPTH-1:0] q_idx_r [CMDQ_DEPTH];
    logic [2:0]           q_cnt_r [CMDQ_DEPTH];
    logic [QA_W-1:0]      q_head_r;
    logic [QA_W-1:0]      q_tail_r;
    logic [QA_W:0]        q_count_r;

    logic                 eng_active_r;
    logic [MEM_DEPTH-1:0] eng_idx_r;
    logic [2:0]           eng_left_r;

    logic [READ_LATENCY-1:0] pipe_vld_r;
    logic [511:0]            pipe_data_r [READ_LATENCY];

    logic [31:0]          rd_cmd_count_r;
    logic [31:0]          wr_beat_count_r;
    logic [1:0]           err_flags_r;

    logic [63:0]          addr_off_s;
    logic [MEM_DEPTH-1:0] cmd_idx_s;
    logic                 addr_oor_s;
    logic                 addr_lsb_unused_s;
    logic                 q_full_s;
    logic                 q_empty_s;
    logic                 rd_pending_s;
    logic                 wait_s;
    logic                 rd_acc_s;
    logic                 wr_acc_s;
    logic [MEM_DEPTH-1:0] wr_mem_idx_s;
    logic                 issue_s;
    logic                 pop_s;
    logic [MEM_DEPTH-1:0] issue_idx_s;
    logic [2:0]           issue_left_s;

`ifdef WAITREQ_INJECT_EN
    logic [15:0]          lfsr_r;

    // Fibonacci LFSR (taps 16,14,13,11) driving random stall injection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end
`endif

    // Byte address to word index; out-of-range accesses wrap but are flagged
    always_comb begin
        addr_off_s = s_address - BASE_ADDR;
        cmd_idx_s  = addr_off_s[MEM_DEPTH+5:6];
        addr_oor_s = (s_address < BASE_ADDR) || (|addr_off_s[63:MEM_DEPTH+6]);
    end

    assign addr_lsb_unused_s = ^addr_off_s[5:0];

    // Queue occupancy and outstanding read activity
    always_comb begin
        q_full_s     = (q_count_r == (QA_W+1)'(CMDQ_DEPTH));
        q_empty_s    = ~|q_count_r;
        rd_pending_s = ~q_empty_s | eng_active_r | (|pipe_vld_r);
    end

    // Structural waitrequest: reads never overtake a write burst, writes wait for reads to drain
    always_comb begin
        wait_s = 1'b0;
        if (!reset) begin
            wait_s = 1'b1;
        end else if (s_read && s_write) begin
            wait_s = 1'b1;
        end else if (s_read && (q_full_s || (wr_state_r == WR_BURST))) begin
            wait_s = 1'b1;
        end else if (s_write && rd_pending_s) begin
            wait_s = 1'b1;
        end else begin
            wait_s = 1'b0;
        end
`ifdef WAITREQ_INJECT_EN
        if (lfsr_r[0]) begin
            wait_s = 1'b1;
        end else begin
            wait_s = wait_s;
        end
`endif
    end

    assign s_waitrequest = wait_s;
    assign rd_acc_s      = s_read & ~wait_s;
    assign wr_acc_s      = s_write & ~wait_s;
    assign wr_mem_idx_s  = (wr_state_r == WR_BURST) ? wr_idx_r : cmd_idx_s;

    // Read engine issue select: continue active burst, else take queue head without a bubble
    always_comb begin
        issue_s      = 1'b0;
        pop_s        = 1'b0;
        issue_idx_s  = eng_idx_r;
        issue_left_s = 3'd0;
        if (eng_active_r) begin
            issue_s      = 1'b1;
            issue_idx_s  = eng_idx_r;
            issue_left_s = eng_left_r;
        end else if (!q_empty_s) begin
            issue_s      = 1'b1;
            pop_s        = 1'b1;
            issue_idx_s  = q_idx_r[q_head_r];
            issue_left_s = q_cnt_r[q_head_r];
        end else begin
            issue_s      = 1'b0;
        end
    end

    // Word memory with per-byte write enables; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            for (int k = 0; k < 64; k++) begin
                if (s_byteenable[k]) begin
                    mem_r[wr_mem_idx_s][k*8 +: 8] <= s_writedata[k*8 +: 8];
                end
            end
        end
    end

    // Write FSM tracks the next index and remaining beats of a burst
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_state_r <= WR_IDLE;
            wr_idx_r   <= {MEM_DEPTH{1'b0}};
            wr_left_r  <= 3'd0;
        end else begin
            case (wr_state_r)
                WR_IDLE: begin
                    if (wr_acc_s && (eff_burst(s_burstcount) > 3'd1)) begin
                        wr_state_r <= WR_BURST;
                        wr_idx_r   <= cmd_idx_s + 1'b1;
                        wr_left_r  <= eff_burst(s_burstcount) - 3'd1;
                    end
                end
                WR_BURST: begin
                    if (wr_acc_s) begin
                        wr_idx_r  <= wr_idx_r + 1'b1;
                        wr_left_r <= wr_left_r - 3'd1;
                        if (wr_left_r == 3'd1) begin
                            wr_state_r <= WR_IDLE;
                        end
                    end
                end
                default: begin
                    wr_state_r <= WR_IDLE;
                end
            endcase
        end
    end

    // Read command queue; full is judged on the registered count, before any same-cycle pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_head_r  <= {QA_W{1'b0}};
            q_tail_r  <= {QA_W{1'b0}};
            q_count_r <= {(QA_W+1){1'b0}};
            for (int i = 0; i < CMDQ_DEPTH; i++) begin
                q_idx_r[i] <= {MEM_DEPTH{1'b0}};
                q_cnt_r[i] <= 3'd0;
            end
        end else begin
            if (rd_acc_s) begin
                q_idx_r[q_tail_r] <= cmd_idx_s;
                q_cnt_r[q_tail_r] <= eff_burst(s_burstcount);
                q_tail_r          <= q_tail_r + 1'b1;
            end
            if (pop_s) begin
                q_head_r <= q_head_r + 1'b1;
            end
            if (rd_acc_s && !pop_s) begin
                q_count_r <= q_count_r + 1'b1;
            end else if (!rd_acc_s && pop_s) begin
                q_count_r <= q_count_r - 1'b1;
            end
        end
    end

    // Read engine burst bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_active_r <= 1'b0;
            eng_idx_r    <= {MEM_DEPTH{1'b0}};
            eng_left_r   <= 3'd0;
        end else if (issue_s && (issue_left_s > 3'd1)) begin
            eng_active_r <= 1'b1;
            eng_idx_r    <= issue_idx_s + 1'b1;
            eng_left_r   <= issue_left_s - 3'd1;
        end else begin
            eng_active_r <= 1'b0;
        end
    end

    // Fixed-latency read pipeline; stage 0 is the memory access register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld_r <= {READ_LATENCY{1'b0}};
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_r[i] <= 512'd0;
            end
        end else begin
            pipe_vld_r[0]  <= issue_s;
            pipe_data_r[0] <= issue_s ? mem_r[issue_idx_s] : 512'd0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_data_r[i] <= pipe_data_r[i-1];
            end
        end
    end

    // Acceptance counters and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cmd_count_r  <= 32'd0;
            wr_beat_count_r <= 32'd0;
            err_flags_r     <= 2'b00;
        end else begin
            if (rd_acc_s) begin
                rd_cmd_count_r <= rd_cmd_count_r + 32'd1;
            end
            if (wr_acc_s) begin
                wr_beat_count_r <= wr_beat_count_r + 32'd1;
            end
            if ((rd_acc_s || (wr_acc_s && (wr_state_r == WR_IDLE))) && addr_oor_s) begin
                err_flags_r[0] <= 1'b1;
            end
            if (s_read && s_write) begin
                err_flags_r[1] <= 1'b1;
            end
        end
    end

    assign s_readdatavalid = pipe_vld_r[READ_LATENCY-1];
    assign s_readdata      = pipe_data_r[READ_LATENCY-1];
    assign rd_cmd_count    = rd_cmd_count_r;
    assign wr_beat_count   = wr_beat_count_r;
    assign err_flags       = err_flags_r;

endmodule
